// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
//
// Purpose:
//   Multi-slot branch resolution stage. Keeps the EQ/GT flags written by
//   compare ops, resolves up to NUM_SLOTS branches per cycle (oldest slot
//   wins), issues a registered one-cycle PC redirect to fetch, and then holds
//   br_ready low for FLUSH_CYCLES cycles while wrong-path work drains.
//
// Optional feature macro: BRANCH_PREDICT_EN
//   When defined, an extra input br_pred_taken is present. A slot redirects
//   only when it was mispredicted: taken and predicted not-taken redirects to
//   the target, and not-taken but predicted taken redirects to br_pc+1.
//   When undefined, every taken branch redirects to its target.
//
// Ports:
//   clk, rst_n               clock (rising edge), async active-low reset
//   cmp_valid/cmp_eq/cmp_gt  compare result; loads the flags at this edge
//   br_valid/br_uncond/
//   br_beq/br_bgt            per-slot branch present and branch type bits
//   br_target, br_pc         per-slot target and branch PC, slot i at [i*PC_W +: PC_W]
//   br_pred_taken            per-slot prediction (BRANCH_PREDICT_EN only)
//   br_ready                 unit accepts branches this cycle
//   redirect_valid           one-cycle pulse: fetch loads redirect_pc
//   redirect_pc/_slot        new fetch PC and the slot that caused it
//   flush_younger            one-cycle pulse: slots younger than the winner
//   flag_eq/flag_gt          current flags register
//   taken_count              saturating count of taken branches
//
// Handshake: a branch in slot i is consumed only in a cycle where
//   br_valid[i] and br_ready are both high; branches presented while
//   br_ready is low are dropped (the front end is squashing them anyway).
// -----------------------------------------------------------------------------
module branch_resolve_unit #(
  parameter int PC_W         = 16,
  parameter int NUM_SLOTS    = 2,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16,
  localparam int SLOT_W      = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmp_valid,
  input  logic                      cmp_eq,
  input  logic                      cmp_gt,
  input  logic [NUM_SLOTS-1:0]      br_valid,
  input  logic [NUM_SLOTS-1:0]      br_uncond,
  input  logic [NUM_SLOTS-1:0]      br_beq,
  input  logic [NUM_SLOTS-1:0]      br_bgt,
  input  logic [NUM_SLOTS*PC_W-1:0] br_target,
  input  logic [NUM_SLOTS*PC_W-1:0] br_pc,
`ifdef BRANCH_PREDICT_EN
  input  logic [NUM_SLOTS-1:0]      br_pred_taken,
`endif
  output logic                      br_ready,
  output logic                      redirect_valid,
  output logic [PC_W-1:0]           redirect_pc,
  output logic [SLOT_W-1:0]         redirect_slot,
  output logic [NUM_SLOTS-1:0]      flush_younger,
  output logic                      flag_eq,
  output logic                      flag_gt,
  output logic [CNT_W-1:0]          taken_count
);

  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [FC_W-1:0]   cnt_q, cnt_d;

  logic [NUM_SLOTS-1:0] taken;
  logic [NUM_SLOTS-1:0] redir;
  logic                 have_win;
  logic [SLOT_W-1:0]    win_idx;
  logic [PC_W-1:0]      win_pc;
  logic [NUM_SLOTS-1:0] flush_mask;
  logic                 count_inc;

  assign br_ready = (state_q == IDLE);

  // Flags: a compare in the same cycle as a branch is not seen by it,
  // because resolution below reads the registered flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_eq <= 1'b0;
      flag_gt <= 1'b0;
    end else if (cmp_valid) begin
      flag_eq <= cmp_eq;
      flag_gt <= cmp_gt;
    end
  end

  // Resolution and winner selection.
  always_comb begin
    taken      = '0;
    redir      = '0;
    have_win   = 1'b0;
    win_idx    = '0;
    win_pc     = '0;
    flush_mask = '0;
    count_inc  = 1'b0;

    for (int i = 0; i < NUM_SLOTS; i++) begin
      taken[i] = br_valid[i] & br_ready &
                 (br_uncond[i] | (br_beq[i] & flag_eq) | (br_bgt[i] & flag_gt));
`ifdef BRANCH_PREDICT_EN
      redir[i] = br_valid[i] & br_ready & (taken[i] ^ br_pred_taken[i]);
`else
      redir[i] = taken[i];
`endif
    end

    // Descending scan so the lowest (oldest) redirecting slot is left last.
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (redir[i]) begin
        have_win = 1'b1;
        win_idx  = SLOT_W'(i);
      end
    end

    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (have_win && (SLOT_W'(i) == win_idx)) begin
        if (taken[i]) win_pc = br_target[i*PC_W +: PC_W];
        else          win_pc = br_pc[i*PC_W +: PC_W] + PC_W'(1);  // wraps modulo 2^PC_W
      end
      flush_mask[i] = have_win && (i > int'(win_idx));
    end

`ifdef BRANCH_PREDICT_EN
    // Count an actual taken branch among the slots that really execute:
    // everything up to and including the winner, or all slots if none redirects.
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (taken[i] && (!have_win || (i <= int'(win_idx)))) count_inc = 1'b1;
    end
`else
    count_inc = have_win;
`endif
  end

  // FSM next state: FLUSH lasts exactly FLUSH_CYCLES cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (have_win) begin
          state_d = FLUSH;
          cnt_d   = FC_W'(FLUSH_CYCLES);
        end
      end
      FLUSH: begin
        if (cnt_q <= FC_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - FC_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered redirect; pc/slot hold their last value between redirects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      redirect_slot  <= '0;
      flush_younger  <= '0;
      taken_count    <= '0;
    end else begin
      redirect_valid <= have_win;
      flush_younger  <= flush_mask;
      if (have_win) begin
        redirect_pc   <= win_pc;
        redirect_slot <= win_idx;
      end
      if (count_inc && (taken_count != {CNT_W{1'b1}})) begin
        taken_count <= taken_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_unit
//   Directed-vector bench for branch_resolve_unit (NUM_SLOTS=2, PC_W=16,
//   FLUSH_CYCLES=2, CNT_W=4 so saturation is reachable quickly).
// -----------------------------------------------------------------------------
module tb_branch_resolve_unit;

  localparam int PC_W  = 16;
  localparam int NS    = 2;
  localparam int CNT_W = 4;

  logic              clk;
  logic              rst_n;
  logic              cmp_valid, cmp_eq, cmp_gt;
  logic [NS-1:0]     br_valid, br_uncond, br_beq, br_bgt;
  logic [NS*PC_W-1:0] br_target, br_pc;
`ifdef BRANCH_PREDICT_EN
  logic [NS-1:0]     br_pred_taken;
`endif
  logic              br_ready;
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic [0:0]        redirect_slot;
  logic [NS-1:0]     flush_younger;
  logic              flag_eq, flag_gt;
  logic [CNT_W-1:0]  taken_count;

  int n_checks = 0;
  int n_fail   = 0;

  branch_resolve_unit #(
    .PC_W(PC_W), .NUM_SLOTS(NS), .FLUSH_CYCLES(2), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmp_valid(cmp_valid), .cmp_eq(cmp_eq), .cmp_gt(cmp_gt),
    .br_valid(br_valid), .br_uncond(br_uncond), .br_beq(br_beq), .br_bgt(br_bgt),
    .br_target(br_target), .br_pc(br_pc),
`ifdef BRANCH_PREDICT_EN
    .br_pred_taken(br_pred_taken),
`endif
    .br_ready(br_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_slot(redirect_slot), .flush_younger(flush_younger),
    .flag_eq(flag_eq), .flag_gt(flag_gt), .taken_count(taken_count)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checker
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cmp_valid = 0; cmp_eq = 0; cmp_gt = 0;
    br_valid = '0; br_uncond = '0; br_beq = '0; br_bgt = '0;
    br_target = '0; br_pc = '0;
`ifdef BRANCH_PREDICT_EN
    br_pred_taken = '0;
`endif
  endtask

  task automatic set_slot(input int i, input logic v, input logic u, input logic eq,
                          input logic gt, input logic [PC_W-1:0] tgt, input logic [PC_W-1:0] pc);
    br_valid[i]  = v;
    br_uncond[i] = u;
    br_beq[i]    = eq;
    br_bgt[i]    = gt;
    br_target[i*PC_W +: PC_W] = tgt;
    br_pc[i*PC_W +: PC_W]     = pc;
  endtask

  task automatic set_cmp(input logic eq, input logic gt);
    cmp_valid = 1; cmp_eq = eq; cmp_gt = gt;
  endtask

  int exp_cnt;

  initial begin
    clear_inputs();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
    step();

    // Reset values
    check("rst_ready", br_ready, 1);
    check("rst_rv", redirect_valid, 0);
    check("rst_pc", redirect_pc, 0);
    check("rst_cnt", taken_count, 0);
    check("rst_flags", {flag_eq, flag_gt}, 0);

    // Type bits ignored when br_valid=0
    set_slot(0, 0, 1, 0, 0, 16'h5555, 16'h0);
    step();
    check("novalid_rv", redirect_valid, 0);
    check("novalid_ready", br_ready, 1);
    clear_inputs();

    // Slot0 unconditional
    set_slot(0, 1, 1, 0, 0, 16'h1234, 16'h0010);
    step();
    clear_inputs();
    check("t2_rv", redirect_valid, 1);
    check("t2_pc", redirect_pc, 16'h1234);
    check("t2_slot", redirect_slot, 0);
    check("t2_flush", flush_younger, 2'b10);
    check("t2_ready0", br_ready, 0);
    check("t2_cnt", taken_count, 1);
    step();
    check("t2_rv_pulse", redirect_valid, 0);
    check("t2_flush_pulse", flush_younger, 0);
    check("t2_ready1", br_ready, 0);
    step();
    check("t2_ready2", br_ready, 1);

    // Same-cycle compare not seen; next cycle BEQ taken
    set_cmp(1, 0);
    set_slot(1, 1, 0, 1, 0, 16'h0040, 16'h0020);
    step();
    check("t3_flag_eq", flag_eq, 1);
    check("t3_n_rv", redirect_valid, 0);
    check("t3_n_ready", br_ready, 1);
    cmp_valid = 0;
    step();
    clear_inputs();
    check("t3_rv", redirect_valid, 1);
    check("t3_pc", redirect_pc, 16'h0040);
    check("t3_slot", redirect_slot, 1);
    check("t3_flush", flush_younger, 2'b00);
    check("t3_cnt", taken_count, 2);
    step();
    step();
    check("t3_ready", br_ready, 1);

    // GT flag, two taken slots, oldest wins; branch during FLUSH ignored
    set_cmp(0, 1);
    step();
    clear_inputs();
    check("t4_flags", {flag_eq, flag_gt}, 2'b01);
    set_slot(0, 1, 0, 0, 1, 16'h0100, 16'h0030);
    set_slot(1, 1, 1, 0, 0, 16'h0200, 16'h0031);
    step();
    clear_inputs();
    check("t4_rv", redirect_valid, 1);
    check("t4_pc", redirect_pc, 16'h0100);
    check("t4_slot", redirect_slot, 0);
    check("t4_flush", flush_younger, 2'b10);
    check("t4_cnt", taken_count, 3);
    set_slot(1, 1, 1, 0, 0, 16'h0200, 16'h0031);
    set_cmp(1, 0);  // flags still update during FLUSH
    step();
    check("t4_fl_rv", redirect_valid, 0);
    check("t4_fl_flags", {flag_eq, flag_gt}, 2'b10);
    cmp_valid = 0;
    step();
    check("t4_fl_rv2", redirect_valid, 0);
    check("t4_fl_pc", redirect_pc, 16'h0100);
    check("t4_fl_cnt", taken_count, 3);
    check("t4_ready", br_ready, 1);
    clear_inputs();

`ifdef BRANCH_PREDICT_EN
    // Predicted-taken BEQ that falls through; PC wraps to 0
    set_cmp(0, 0);
    step();
    clear_inputs();
    set_slot(0, 1, 0, 1, 0, 16'h0777, 16'hFFFF);
    br_pred_taken = 2'b01;
    step();
    clear_inputs();
    check("t5_rv", redirect_valid, 1);
    check("t5_pc", redirect_pc, 16'h0000);
    check("t5_cnt", taken_count, 3);
    step();
    step();
    set_slot(0, 1, 0, 1, 0, 16'h0777, 16'hFFFF);
    br_pred_taken = 2'b00;
    step();
    clear_inputs();
    check("t5_np_rv", redirect_valid, 0);
    check("t5_np_ready", br_ready, 1);
`endif

    // Saturation of taken_count (starts at 3)
    exp_cnt = 3;
    for (int k = 0; k < 14; k++) begin
      set_slot(1, 1, 1, 0, 0, PC_W'(16'h0800 + k), 16'h0000);
      step();
      clear_inputs();
      exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
      check("t6_rv", redirect_valid, 1);
      check("t6_pc", redirect_pc, 32'(16'h0800 + k));
      check("t6_cnt", taken_count, exp_cnt);
      step();
      step();
    end
    check("t6_sat", taken_count, 4'hF);

    // Async reset in the middle of FLUSH
    set_slot(0, 1, 1, 0, 0, 16'hABCD, 16'h0);
    set_cmp(1, 1);
    step();
    clear_inputs();
    check("t1_pre_ready", br_ready, 0);
    #2;
    rst_n = 0;
    #1;
    check("t1_ready", br_ready, 1);
    check("t1_rv", redirect_valid, 0);
    check("t1_pc", redirect_pc, 0);
    check("t1_slot", redirect_slot, 0);
    check("t1_flush", flush_younger, 0);
    check("t1_flags", {flag_eq, flag_gt}, 0);
    check("t1_cnt", taken_count, 0);
    step();
    rst_n = 1;
    step();
    check("t1_after_ready", br_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
